// File: rtl/condicionador_entradas.sv
// condicionador_entradas: synchronizes and debounces the four game keys and the jogar button,
// producing a held one-hot key pattern plus single-cycle press pulses.
module condicionador_entradas #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CONT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves_brutas,
  input  logic       jogar_bruto,
  output logic [3:0] chaves,
  output logic       jogada_pulso,
  output logic       jogar_pulso,
  output logic       multiplas,
  output logic [2:0] db_estado_cond
);
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    FILTRANDO = 3'd1,
    VALIDO    = 3'd2,
    LIBERANDO = 3'd3,
    MULTIPLA  = 3'd4
  } estado_t;
  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);
  logic [3:0]        meta_q, sinc_q;
  logic              jogar_meta_q, jogar_sinc_q;
  estado_t           estado_q;
  logic [3:0]        cand_q, chaves_q;
  logic [CONT_W-1:0] cnt_q, jogar_cnt_q;
  logic              jogada_q, mult_q;
  logic              estavel_q, estavel_ant_q, jogar_pulso_q;
  logic              um_quente;
  assign um_quente = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      meta_q       <= 4'd0;
      sinc_q       <= 4'd0;
      jogar_meta_q <= 1'b0;
      jogar_sinc_q <= 1'b0;
    end else begin
      meta_q       <= chaves_brutas;
      sinc_q       <= meta_q;
      jogar_meta_q <= jogar_bruto;
      jogar_sinc_q <= jogar_meta_q;
    end
  // Any departure from the accepted pattern forces a full clean release before the next jogada.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado_q <= OCIOSO;
      cand_q   <= 4'd0;
      cnt_q    <= '0;
      chaves_q <= 4'd0;
      jogada_q <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      jogada_q <= 1'b0;
      case (estado_q)
        OCIOSO:
          if (sinc_q != 4'd0) begin
            cand_q   <= sinc_q;
            cnt_q    <= '0;
            estado_q <= FILTRANDO;
          end
        FILTRANDO:
          if (sinc_q == cand_q) begin
            if (cnt_q == LIMITE) begin
              if (um_quente) begin
                estado_q <= VALIDO;
                chaves_q <= cand_q;
                jogada_q <= 1'b1;
              end else begin
                estado_q <= MULTIPLA;
                mult_q   <= 1'b1;
              end
            end else cnt_q <= cnt_q + 1'b1;
          end else if (sinc_q == 4'd0) estado_q <= OCIOSO;
          else begin
            cand_q <= sinc_q;
            cnt_q  <= '0;
          end
        VALIDO:
          if (sinc_q != cand_q) begin
            cnt_q    <= '0;
            estado_q <= LIBERANDO;
          end
        LIBERANDO:
          if (sinc_q != 4'd0) cnt_q <= '0;
          else if (cnt_q == LIMITE) begin
            estado_q <= OCIOSO;
            chaves_q <= 4'd0;
          end else cnt_q <= cnt_q + 1'b1;
        MULTIPLA:
          if (sinc_q == 4'd0) begin
            cnt_q    <= '0;
            mult_q   <= 1'b0;
            estado_q <= LIBERANDO;
          end
        default: begin
          estado_q <= OCIOSO;
          cand_q   <= 4'd0;
          chaves_q <= 4'd0;
          mult_q   <= 1'b0;
        end
      endcase
    end
  // The pulse is taken one cycle after the stable level rises so it lines up with jogada_pulso.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      jogar_cnt_q   <= '0;
      estavel_q     <= 1'b0;
      estavel_ant_q <= 1'b0;
      jogar_pulso_q <= 1'b0;
    end else begin
      estavel_ant_q <= estavel_q;
      jogar_pulso_q <= estavel_q & ~estavel_ant_q;
      if (jogar_sinc_q != estavel_q) begin
        if (jogar_cnt_q == LIMITE) begin
          estavel_q   <= ~estavel_q;
          jogar_cnt_q <= '0;
        end else jogar_cnt_q <= jogar_cnt_q + 1'b1;
      end else jogar_cnt_q <= '0;
    end
  assign chaves         = chaves_q;
  assign jogada_pulso   = jogada_q;
  assign jogar_pulso    = jogar_pulso_q;
  assign multiplas      = mult_q;
  assign db_estado_cond = estado_q;
endmodule

// File: tb/tb_condicionador_entradas.sv
// tb_condicionador_entradas: directed checks of debounce latency, bounce/multi-key rejection,
// release discipline, the jogar channel and asynchronous reset, with DEBOUNCE_CICLOS=4.
module tb_condicionador_entradas;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] chaves_brutas = 4'd0;
  logic       jogar_bruto = 1'b0;
  logic [3:0] chaves;
  logic       jogada_pulso, jogar_pulso, multiplas;
  logic [2:0] db_estado_cond;
  int checks = 0;
  int errors = 0;
  int n_jog = 0;
  int n_jogar = 0;
  int base;
  condicionador_entradas #(.DEBOUNCE_CICLOS(4), .CONT_W(16)) dut (
    .clock(clock), .reset(reset), .chaves_brutas(chaves_brutas), .jogar_bruto(jogar_bruto),
    .chaves(chaves), .jogada_pulso(jogada_pulso), .jogar_pulso(jogar_pulso),
    .multiplas(multiplas), .db_estado_cond(db_estado_cond)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (jogada_pulso) n_jog++;
    if (jogar_pulso) n_jogar++;
  end
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    step(2);
    check("rst_chaves", chaves, 8'h0);
    check("rst_estado", db_estado_cond, 8'h0);
    check("rst_mult", multiplas, 8'h0);
    check("rst_pulsos", {jogada_pulso, jogar_pulso}, 8'h0);
    reset = 1'b1;
    step(2);
    base = n_jog;
    chaves_brutas = 4'b0010;
    step(6);
    check("t1_pulso_cedo", jogada_pulso, 8'h0);
    check("t1_chaves_cedo", chaves, 8'h0);
    step(1);
    check("t1_pulso", jogada_pulso, 8'h1);
    check("t1_chaves", chaves, 8'h2);
    check("t1_estado", db_estado_cond, 8'h2);
    step(1);
    check("t1_pulso_fim", jogada_pulso, 8'h0);
    step(10);
    check("t1_chaves_hold", chaves, 8'h2);
    check("t1_n_pulsos", n_jog - base, 8'h1);
    chaves_brutas = 4'b0000;
    step(6);
    check("t1_lib_chaves", chaves, 8'h2);
    check("t1_lib_estado", db_estado_cond, 8'h3);
    step(1);
    check("t1_solto_chaves", chaves, 8'h0);
    check("t1_solto_estado", db_estado_cond, 8'h0);
    base = n_jog;
    for (int i = 0; i < 5; i++) begin
      chaves_brutas = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      step(2);
    end
    check("t2_sem_pulso_bounce", n_jog - base, 8'h0);
    step(12);
    check("t2_n_pulsos", n_jog - base, 8'h1);
    check("t2_chaves", chaves, 8'h4);
    chaves_brutas = 4'b0000;
    step(10);
    check("t2_solto", {db_estado_cond, chaves}, 8'h0);
    base = n_jog;
    chaves_brutas = 4'b0011;
    step(8);
    check("t3_mult", multiplas, 8'h1);
    check("t3_estado", db_estado_cond, 8'h4);
    check("t3_chaves", chaves, 8'h0);
    step(2);
    check("t3_sem_pulso", n_jog - base, 8'h0);
    chaves_brutas = 4'b0000;
    step(3);
    check("t3_mult_off", multiplas, 8'h0);
    check("t3_estado_lib", db_estado_cond, 8'h3);
    step(4);
    check("t3_estado_ocioso", db_estado_cond, 8'h0);
    base = n_jog;
    chaves_brutas = 4'b1000;
    step(7);
    check("t4_pulso", jogada_pulso, 8'h1);
    step(3);
    for (int i = 0; i < 3; i++) begin
      chaves_brutas = 4'b0000;
      step(1);
      chaves_brutas = 4'b1000;
      step(1);
    end
    step(10);
    check("t4_sem_repulso", n_jog - base, 8'h1);
    check("t4_estado", db_estado_cond, 8'h3);
    check("t4_chaves_hold", chaves, 8'h8);
    chaves_brutas = 4'b0000;
    step(4);
    check("t4_lib_chaves", chaves, 8'h8);
    chaves_brutas = 4'b1000;
    step(2);
    check("t4_ocioso", {db_estado_cond, chaves}, 8'h0);
    step(4);
    check("t4_pulso2_cedo", jogada_pulso, 8'h0);
    step(1);
    check("t4_pulso2", jogada_pulso, 8'h1);
    check("t4_chaves2", chaves, 8'h8);
    chaves_brutas = 4'b0000;
    step(10);
    check("t4_n_pulsos", n_jog - base, 8'h2);
    base = n_jogar;
    jogar_bruto = 1'b1;
    step(3);
    jogar_bruto = 1'b0;
    step(10);
    check("t5_jogar_curto", n_jogar - base, 8'h0);
    jogar_bruto = 1'b1;
    chaves_brutas = 4'b0001;
    step(6);
    check("t5_jogar_cedo", jogar_pulso, 8'h0);
    jogar_bruto = 1'b0;
    step(1);
    check("t5_simultaneo", {jogar_pulso, jogada_pulso}, 8'h3);
    step(1);
    check("t5_jogar_fim", jogar_pulso, 8'h0);
    step(10);
    check("t5_n_jogar", n_jogar - base, 8'h1);
    check("t6_valido", db_estado_cond, 8'h2);
    reset = 1'b0;
    #1;
    check("t6_rst_chaves", chaves, 8'h0);
    check("t6_rst_estado", db_estado_cond, 8'h0);
    step(2);
    reset = 1'b1;
    step(6);
    check("t6_pulso_cedo", jogada_pulso, 8'h0);
    step(1);
    check("t6_pulso", jogada_pulso, 8'h1);
    check("t6_chaves", chaves, 8'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/condicionador_entradas.md
Name: condicionador_entradas

Overview:
- Input-conditioning stage directly upstream of the memory-game top level (circuito_exp6).
- Takes the four raw push-button keys and the raw "jogar" button, and synchronizes and debounces them.
- Presents a clean, held one-hot key pattern on `chaves`, plus single-cycle event pulses.
- Rejects multi-key presses and swallows contact bounce, so the game FSM sees exactly one jogada per physical press.

Parameters:
- DEBOUNCE_CICLOS, 50000: consecutive stable cycles required to accept a level change (1 ms at 50 MHz); legal range 1..2^CONT_W.
- CONT_W, 16: width of each debounce counter.

Ports:
- clock  in  1  system clock, all flops on rising edge
- reset  in  1  asynchronous, active-low; 0 clears every flop immediately
- chaves_brutas  in  4  raw keys, 1 = pressed, asynchronous to clock
- jogar_bruto  in  1  raw start button, 1 = pressed, asynchronous
- chaves  out  4  debounced one-hot key pattern, held while the key is accepted; feeds game `chaves`
- jogada_pulso  out  1  one-cycle pulse when a valid single-key press is accepted
- jogar_pulso  out  1  one-cycle pulse on accepted rising edge of jogar; feeds game `jogar`
- multiplas  out  1  level, high while a debounced multi-key press is being rejected
- db_estado_cond  out  3  current key-FSM state code, for debug display

Behaviour:
- Reset (reset=0):
  - Synchronizers, counters, `cand` and `chaves` all go to 0.
  - State = OCIOSO; all outputs 0; internal `jogar_estavel` = 0.
- Synchronization:
  - Each raw bit passes through 2 flops; the FSM and counters see only the second flop (`sinc`).
- Key FSM states and codes: OCIOSO=0, FILTRANDO=1, VALIDO=2, LIBERANDO=3, MULTIPLA=4. Codes 5-7 are unreachable and recover to OCIOSO.
- OCIOSO:
  - sinc==0: stay.
  - Otherwise: cand<=sinc, cnt<=0, go to FILTRANDO.
- FILTRANDO:
  - sinc==cand: cnt++.
  - sinc!=cand and sinc==0: go to OCIOSO.
  - sinc!=cand and nonzero: cand<=sinc, cnt<=0.
  - When sinc==cand and cnt==DEBOUNCE_CICLOS-1:
    - cand one-hot: go to VALIDO, chaves<=cand, jogada_pulso<=1 for exactly one cycle.
    - cand not one-hot: go to MULTIPLA, chaves stays 0.
- VALIDO:
  - chaves held.
  - sinc!=cand (release, a bounce, or an added key): cnt<=0, go to LIBERANDO.
- LIBERANDO:
  - chaves still held.
  - sinc==0: cnt++. sinc!=0: cnt<=0.
  - sinc==0 and cnt==DEBOUNCE_CICLOS-1: go to OCIOSO, chaves<=0.
  - A re-press during LIBERANDO never produces a second jogada_pulso; full release is required first.
- MULTIPLA:
  - multiplas=1.
  - sinc==0: cnt<=0, go to LIBERANDO.
- Latency:
  - Number the first edge that samples a stable press as edge 1.
  - jogada_pulso is high after edge DEBOUNCE_CICLOS+3.
  - chaves updates on the same edge as jogada_pulso.
  - chaves clears DEBOUNCE_CICLOS+3 edges after a stable release (the first sampling edge of the release counted as edge 1).
- Output registering: all outputs are registered; no combinational path from raw inputs.
- jogar channel:
  - Has its own counter, independent of the key FSM.
  - While sinc_jogar!=jogar_estavel: count; on reaching DEBOUNCE_CICLOS-1, toggle jogar_estavel and clear the counter.
  - While equal: counter stays 0.
  - jogar_pulso=1 for one cycle when jogar_estavel rises 0->1; nothing on the fall.
- Simultaneity: jogar and keys are fully independent; jogar_pulso and jogada_pulso may assert in the same cycle.
- Reset mid-press: a key held across reset deassertion is treated as a new press (full debounce, then one pulse).
- DEBOUNCE_CICLOS=1: a level change is accepted after one stable cycle; the FSM remains legal.

Test Plan:
- DEBOUNCE_CICLOS=4. Hold chaves_brutas=0010 clean -> single jogada_pulso after edge 7; chaves=0010 held until release; chaves=0000 7 edges after release.
- Press 0100 with bounce 0100/0000 toggling every 2 cycles for 10 cycles, then stable -> exactly one jogada_pulso; chaves=0100; no pulse during the bounce.
- Stable 0011 for 8 cycles -> multiplas=1, chaves=0000, no jogada_pulso. Release -> multiplas=0 and state returns to OCIOSO (db_estado_cond=0).
- Valid 1000 accepted, then release 1 cycle and re-press, repeated for 3 cycles, then hold -> no second pulse until a 4-cycle clean release followed by a new press.
- jogar_bruto high 3 cycles then low -> no jogar_pulso. High 6 cycles -> one jogar_pulso after edge 7, concurrent with a key press pulse in the same cycle when aligned.
- Assert reset=0 while in VALIDO with 0001 held -> outputs 0 immediately. Release reset with key still held -> new jogada_pulso after edge 7.
